// File: rtl/wb_decode_n.sv
// Wishbone address decoder: routes one upstream transaction at a time to one of
// N_SLV slaves, with error ack for unmapped addresses, timeout, abort and error count.
module wb_decode_n #(
  parameter int unsigned         N_SLV    = 4,
  parameter int unsigned         AW       = 32,
  parameter int unsigned         DW       = 32,
  parameter logic [N_SLV*AW-1:0] BASE     = {N_SLV{32'h3000_0000}},
  parameter logic [N_SLV*AW-1:0] MASK     = {N_SLV{32'hFFFF_0000}},
  parameter int unsigned         TIMEOUT  = 255,
  parameter logic [DW-1:0]       ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [DW/8-1:0]     wbs_sel_i,
  input  logic [AW-1:0]       wbs_adr_i,
  input  logic [DW-1:0]       wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [DW-1:0]       wbs_dat_o,
  output logic [N_SLV-1:0]    m_cyc_o,
  output logic [N_SLV-1:0]    m_stb_o,
  output logic                m_we_o,
  output logic [DW/8-1:0]     m_sel_o,
  output logic [AW-1:0]       m_adr_o,
  output logic [DW-1:0]       m_dat_o,
  input  logic [N_SLV-1:0]    m_ack_i,
  input  logic [N_SLV*DW-1:0] m_dat_i,
  output logic                err_o,
  output logic [7:0]          err_cnt_o
);

  localparam int unsigned IW       = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, ERR} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d, hit_idx;
  logic [N_SLV-1:0]  hit_vec, strb_d;
  logic              hit;
  logic [15:0]       cnt_q, cnt_d, cnt_inc;
  logic              ack_d, err_d, go_err;
  logic [DW-1:0]     rdat_d;
  logic [7:0]        err_cnt_d;
  logic              m_we_d;
  logic [DW/8-1:0]   m_sel_d;
  logic [AW-1:0]     m_adr_d;
  logic [DW-1:0]     m_dat_d;
  logic              sel_ack;
  logic [DW-1:0]     sel_dat;

  // First matching slot claims the address, so lower indices win overlaps.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_vec = '0;
    for (int unsigned i = 0; i < N_SLV; i++) begin
      if (!hit && ((wbs_adr_i & MASK[i*AW +: AW]) == (BASE[i*AW +: AW] & MASK[i*AW +: AW]))) begin
        hit        = 1'b1;
        hit_idx    = IW'(i);
        hit_vec[i] = 1'b1;
      end
    end
  end

  assign sel_ack = m_ack_i[idx_q];
  assign sel_dat = m_dat_i[idx_q*DW +: DW];
  assign cnt_inc = cnt_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    strb_d    = '0;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    go_err    = 1'b0;
    rdat_d    = wbs_dat_o;
    err_cnt_d = err_cnt_o;
    m_we_d    = m_we_o;
    m_sel_d   = m_sel_o;
    m_adr_d   = m_adr_o;
    m_dat_d   = m_dat_o;
    unique case (state_q)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          m_we_d  = wbs_we_i;
          m_sel_d = wbs_sel_i;
          m_adr_d = wbs_adr_i;
          m_dat_d = wbs_dat_i;
          idx_d   = hit_idx;
          cnt_d   = '0;
          if (hit) begin
            state_d = BUSY;
            strb_d  = hit_vec;
          end else begin
            go_err = 1'b1;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_inc;
        if (sel_ack) begin
          state_d = RESP;
          ack_d   = 1'b1;
          rdat_d  = sel_dat;
        end else if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else if (cnt_inc == TO_LIMIT) begin
          go_err = 1'b1;
        end else begin
          strb_d = m_stb_o;
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Error responses are registered on the edge entering ERR so the ack appears in ERR.
    if (go_err) begin
      state_d = ERR;
      ack_d   = 1'b1;
      err_d   = 1'b1;
      rdat_d  = ERR_DATA;
      if (err_cnt_o != 8'hFF) err_cnt_d = err_cnt_o + 8'd1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      m_cyc_o   <= '0;
      m_stb_o   <= '0;
      m_we_o    <= 1'b0;
      m_sel_o   <= '0;
      m_adr_o   <= '0;
      m_dat_o   <= '0;
      err_o     <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      wbs_ack_o <= ack_d;
      wbs_dat_o <= rdat_d;
      m_cyc_o   <= strb_d;
      m_stb_o   <= strb_d;
      m_we_o    <= m_we_d;
      m_sel_o   <= m_sel_d;
      m_adr_o   <= m_adr_d;
      m_dat_o   <= m_dat_d;
      err_o     <= err_d;
      err_cnt_o <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_decode_n.sv
// Self-checking bench for wb_decode_n: directed and random transactions against
// an outcome model derived from the address map and ack/abort/timeout cycle numbers.
module tb_wb_decode_n;

  localparam int unsigned N  = 4;
  localparam int          TO = 8;
  localparam logic [N*32-1:0] BASE_P = {32'h3002_0000, 32'h3001_0000, 32'h3000_0000, 32'h3000_8000};
  localparam logic [N*32-1:0] MASK_P = {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_8000};
  localparam logic [31:0]     ERRD   = 32'hDEAD_BEEF;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cyc, stb, we;
  logic [3:0]     sel;
  logic [31:0]    adr, wdat;
  logic           ack_o;
  logic [31:0]    dat_o;
  logic [N-1:0]   m_cyc, m_stb;
  logic           m_we;
  logic [3:0]     m_sel;
  logic [31:0]    m_adr, m_dat;
  logic [N-1:0]   m_ack;
  logic [N*32-1:0] m_dat_in;
  logic           err;
  logic [7:0]     err_cnt;

  int checks = 0;
  int fails  = 0;
  int exp_cnt = 0;
  logic [31:0] base_a [N];
  logic [31:0] mask_a [N];

  always #5 clk = ~clk;

  wb_decode_n #(
    .N_SLV(4), .AW(32), .DW(32), .BASE(BASE_P), .MASK(MASK_P),
    .TIMEOUT(TO), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_o), .wbs_dat_o(dat_o),
    .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_sel_o(m_sel),
    .m_adr_o(m_adr), .m_dat_o(m_dat), .m_ack_i(m_ack), .m_dat_i(m_dat_in),
    .err_o(err), .err_cnt_o(err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // d: wait cycles before the target slave acks (<0 never); ka: abort cycle (0 none).
  task automatic run_txn(input logic [31:0] a, input logic w, input logic [3:0] s,
                         input logic [31:0] wd, input int d, input int ka, input logic [31:0] td);
    int tgt, kack, kab, ack_c, busy_end;
    bit is_err;
    logic [3:0]  onehot, exp_stb;
    logic [31:0] slot_dat [N];
    tgt = -1;
    for (int i = 0; i < N; i++)
      if (tgt < 0 && (a & mask_a[i]) == (base_a[i] & mask_a[i])) tgt = i;
    kack = (d < 0) ? 1000 : d + 1;
    kab  = (ka <= 0) ? 1000 : ka;
    is_err = 1'b0;
    if (tgt < 0) begin
      ack_c = 1; is_err = 1'b1; busy_end = 0;
    end else if (kack <= kab && kack <= TO) begin
      ack_c = kack + 1; busy_end = kack;
    end else if (kab < kack && kab <= TO) begin
      ack_c = 0; busy_end = kab;
    end else begin
      ack_c = TO + 1; is_err = 1'b1; busy_end = TO;
    end
    if (is_err) exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
    onehot = (tgt < 0) ? 4'b0 : 4'(1 << tgt);
    for (int i = 0; i < N; i++) slot_dat[i] = $urandom;
    if (tgt >= 0) slot_dat[tgt] = td;
    for (int i = 0; i < N; i++) m_dat_in[i*32 +: 32] = slot_dat[i];
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = wd;
    m_ack = 4'($urandom) & ~onehot;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      exp_stb = (c <= busy_end) ? onehot : 4'b0;
      check("m_stb", 32'(m_stb), 32'(exp_stb));
      check("m_cyc", 32'(m_cyc), 32'(exp_stb));
      check("ack", 32'(ack_o), 32'(c == ack_c));
      check("err", 32'(err), 32'(c == ack_c && is_err));
      if (c == ack_c) check("rdata", dat_o, is_err ? ERRD : td);
      if (c == 1 || c == 20) begin
        check("m_adr", m_adr, a);
        check("m_dat", m_dat, wd);
        check("m_we", 32'(m_we), 32'(w));
        check("m_sel", 32'(m_sel), 32'(s));
      end
      if (ack_o || c == kab) begin cyc = 1'b0; stb = 1'b0; end
      m_ack = 4'($urandom) & ~onehot;
      if (tgt >= 0 && c == kack) m_ack[tgt] = 1'b1;
    end
    m_ack = '0;
    check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
  endtask

  initial begin
    int pick, d, ka;
    logic [31:0] a;
    for (int i = 0; i < N; i++) begin
      base_a[i] = BASE_P[i*32 +: 32];
      mask_a[i] = MASK_P[i*32 +: 32];
    end
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
    m_ack = '0; m_dat_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_stb", 32'(m_stb), 32'd0);
    check("rst_cyc", 32'(m_cyc), 32'd0);
    check("rst_adr", m_adr, 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn(32'h3000_0004, 1'b1, 4'hF, 32'h1234_5678, 0, 0, $urandom);   // mapped write, slave 1
    run_txn(32'h3001_0010, 1'b0, 4'hF, $urandom, 5, 0, 32'hCAFE_0002);    // wait states, slave 2
    run_txn(32'h2000_0000, 1'b0, 4'hF, $urandom, 0, 0, $urandom);         // unmapped
    run_txn(32'h3002_0000, 1'b0, 4'h3, $urandom, -1, 0, $urandom);        // timeout
    run_txn(32'h3000_0100, 1'b0, 4'hF, $urandom, 4, 2, $urandom);         // abort, late ack
    run_txn(32'h3000_8010, 1'b0, 4'hF, $urandom, 1, 0, 32'h0000_AAAA);    // overlap -> slave 0
    run_txn(32'h3001_0000, 1'b0, 4'hF, $urandom, TO - 1, 0, 32'h5555_0001); // ack meets timeout
    run_txn(32'h3002_0040, 1'b0, 4'hF, $urandom, 3, 4, 32'h7777_0003);    // ack same cycle as abort

    for (int n = 0; n < 150; n++) begin
      pick = $urandom_range(0, 5);
      case (pick)
        0: a = 32'h3000_8000 | ($urandom & 32'h0000_7FFF);
        1: a = 32'h3000_0000 | ($urandom & 32'h0000_7FFF);
        2: a = 32'h3001_0000 | ($urandom & 32'h0000_FFFF);
        3: a = 32'h3002_0000 | ($urandom & 32'h0000_FFFF);
        4: a = 32'h2000_0000 | ($urandom & 32'h0000_FFFF);
        default: a = $urandom;
      endcase
      d  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 10));
      ka = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 0;
      run_txn(a, 1'($urandom), 4'($urandom), $urandom, d, ka, $urandom);
    end

    for (int n = 0; n < 300; n++)
      run_txn(32'h2000_0000 + 32'(n * 4), 1'b0, 4'hF, $urandom, 0, 0, $urandom);
    check("err_cnt_sat", 32'(err_cnt), 32'd255);

    // Reset while BUSY on slave 2, then a late ack after reset.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h3001_0020; wdat = 32'hA5A5_5A5A;
    m_ack = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_stb", 32'(m_stb), 32'h4);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mrst_ack", 32'(ack_o), 32'd0);
    check("mrst_dat", dat_o, 32'd0);
    check("mrst_cyc", 32'(m_cyc), 32'd0);
    check("mrst_stb", 32'(m_stb), 32'd0);
    check("mrst_we", 32'(m_we), 32'd0);
    check("mrst_sel", 32'(m_sel), 32'd0);
    check("mrst_adr", m_adr, 32'd0);
    check("mrst_mdat", m_dat, 32'd0);
    check("mrst_err", 32'(err), 32'd0);
    check("mrst_err_cnt", 32'(err_cnt), 32'd0);
    exp_cnt = 0;
    rst_n = 1'b1; cyc = 1'b0; stb = 1'b0; m_ack = 4'b0100;
    @(posedge clk); #1;
    m_ack = '0;
    check("late_ack", 32'(ack_o), 32'd0);
    @(posedge clk); #1;
    check("late_ack2", 32'(ack_o), 32'd0);
    check("late_stb", 32'(m_stb), 32'd0);
    run_txn(32'h3001_0008, 1'b0, 4'hF, $urandom, 2, 0, 32'hBEEF_0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/wb_decode_n.md
# wb_decode_n

Parametrised Wishbone address decoder for the user project area. It sits between the management SoC Wishbone slave port of `user_project_wrapper` and N user peripherals (UART, FIR, matmul and later blocks). It routes each transaction to one of `N_SLV` downstream slaves by base/mask match. It adds behaviour the fixed decoder lacks:

- registered request and response stages;
- a bus-error response for unmapped addresses;
- a per-transaction timeout;
- master-abort handling;
- a saturating error counter.

## Interface

Parameters:
- `N_SLV`, 4, number of downstream slaves (1..8)
- `AW`, 32, address width
- `DW`, 32, data width (multiple of 8)
- `BASE`, {N_SLV{32'h3000_0000}}, packed `N_SLV*AW` base addresses; slot i at `[i*AW +: AW]`
- `MASK`, {N_SLV{32'hFFFF_0000}}, packed `N_SLV*AW` compare masks
- `TIMEOUT`, 255, max cycles waiting for a slave ack (1..65535)
- `ERR_DATA`, 32'hDEAD_BEEF, read data returned on error

Ports:
- `wb_clk_i`  in  1  single clock
- `wb_rst_n`  in  1  reset; synchronous, active-low
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  upstream request
- `wbs_sel_i`  in  DW/8  byte selects
- `wbs_adr_i`  in  AW  address
- `wbs_dat_i`  in  DW  write data
- `wbs_ack_o`  out  1  upstream ack
- `wbs_dat_o`  out  DW  upstream read data
- `m_cyc_o`, `m_stb_o`  out  N_SLV  one-hot downstream strobes
- `m_we_o`  out  1  broadcast
- `m_sel_o`  out  DW/8  broadcast
- `m_adr_o`  out  AW  broadcast
- `m_dat_o`  out  DW  broadcast
- `m_ack_i`  in  N_SLV  per-slave ack
- `m_dat_i`  in  N_SLV*DW  per-slave read data, slot i at `[i*DW +: DW]`
- `err_o`  out  1  one-cycle pulse coincident with an error ack
- `err_cnt_o`  out  8  saturating error count

## Operation

- **Hit rule:** slave i hits when `(wbs_adr_i & MASK_i) == (BASE_i & MASK_i)`. On multiple hits, the lowest index wins.

FSM states: IDLE, BUSY, RESP, ERR.

- **IDLE**
  - Condition: `wbs_cyc_i & wbs_stb_i` sampled high.
  - Latch adr/we/sel/dat into the `m_*` broadcast registers.
  - Latch the winning index and clear the timeout counter.
  - On a hit, go to BUSY. On no hit, go to ERR.
- **BUSY**
  - `m_cyc_o[idx]` and `m_stb_o[idx]` are high; all other bits are 0.
  - Counter increments each cycle.
  - `m_ack_i[idx]`: capture `m_dat_i[idx]` into `wbs_dat_o`, go to RESP.
  - Counter reaches `TIMEOUT` with no ack: go to ERR.
  - `wbs_cyc_i` low (master abort): go to IDLE, with no upstream ack.
  - Priority: ack > abort > timeout.
- **RESP**
  - `wbs_ack_o=1` for exactly one cycle, then go to IDLE.
  - `m_cyc_o` and `m_stb_o` are 0 in this state.
- **ERR**
  - `wbs_ack_o=1`, `wbs_dat_o=ERR_DATA`, `err_o=1` for one cycle.
  - `err_cnt_o` increments and saturates at 255.
  - Then go to IDLE.

Other rules:
- Acks from non-selected slaves are ignored in every state. Any `m_ack_i` seen in IDLE, RESP or ERR is ignored.
- For writes, `wbs_dat_o` is still updated from the slave's data bus. Masters must treat it as don't-care.
- `m_*` broadcast registers hold their value until the next request.

## Timing

- All outputs are registered.
- Reset values: `wbs_ack_o=0`, `wbs_dat_o=0`, `m_cyc_o=0`, `m_stb_o=0`, `m_we_o=0`, `m_sel_o=0`, `m_adr_o=0`, `m_dat_o=0`, `err_o=0`, `err_cnt_o=0`; FSM goes to IDLE.
- Latency, with request sampled at edge 0:
  - `m_stb_o` is high from cycle 1.
  - A slave ack at cycle k gives `wbs_ack_o` at cycle k+1. The minimum is cycle 2, for a slave acking combinationally in cycle 1.
  - An unmapped address gives an error ack at cycle 1.
  - A timeout gives an error ack at cycle `TIMEOUT+1`.
- Throughput: one transaction in flight. A new request is accepted only in IDLE, so there is at least one idle cycle between the upstream ack and the next acceptance.
- **Reset mid-transaction:** downstream strobes drop at the next edge and no ack is issued. A late slave ack after reset is ignored.
- **Abort:** strobes drop one cycle after `wbs_cyc_i` is seen low. A late ack is ignored.
- **Simultaneous ack and timeout expiry in the same cycle:** the ack wins. The response is normal and `err_o` stays 0.

## Test plan

- **Mapped write:** BASE1=0x3000_0000, MASK=0xFFFF_0000. Write 0x3000_0004 with data 0x1234_5678. Slave 1 acks at cycle 1.
  - Required: `m_stb_o=4'b0010`, `m_adr_o=0x3000_0004`, `m_dat_o=0x1234_5678`, `wbs_ack_o` at cycle 2, `err_cnt_o=0`.
- **Mapped read with wait states:** slave 2 returns 0xCAFE_0002 after 5 wait cycles.
  - Required: `wbs_dat_o=0xCAFE_0002` with `wbs_ack_o` one cycle after the slave ack.
- **Unmapped read:** address 0x2000_0000.
  - Required: no `m_stb_o` bit set; ack at cycle 1 with 0xDEAD_BEEF; `err_o` pulse; `err_cnt_o=1`.
- **Timeout:** `TIMEOUT=8`, slave never acks.
  - Required: error ack at cycle 9; strobes drop.
  - Then 300 unmapped accesses: `err_cnt_o` holds at 255.
- **Abort and late ack:** drop `wbs_cyc_i` in BUSY, then slave acks late.
  - Required: no upstream ack; `m_cyc_o=0` next cycle; FSM in IDLE.
- **Overlap and reset:** BASE0 and BASE1 both map 0x3000_xxxx.
  - Required: slave 0 is selected.
  - Assert `wb_rst_n=0` during BUSY: all outputs 0 at the next edge.
